onectr_progmem: RTL and testbench
=================================

Name: onectr_progmem

Overview:
- Loadable program memory and instruction decoder sitting directly upstream of the ones-counter core.
- Takes the core's PCAddress and drives its full control bundle: Ctrl, Sel, Wen, WA, RAA, RAB, Op, JP, JF and JumpAddress.
- A program is loaded word by word over a valid/ready port.
- The block gates the core's start, and outputs only NOPs until a valid program is resident and running.

Parameters:
- PCSIZE, 8: program counter width; memory depth DEPTH = 2**PCSIZE words.
- IWIDTH, 30+PCSIZE: instruction word width (fixed by field layout; not to be overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- prog_start_i  in  1  request to (re)load a program.
- prog_valid_i  in  1  prog_data_i valid.
- prog_ready_o  out  1  block accepts a word this cycle.
- prog_data_i  in  IWIDTH  instruction word.
- prog_last_i  in  1  current word is the final program word.
- start_i  in  1  run request from the system.
- start_o  out  1  start pulse to the core.
- PCAddress  in  PCSIZE  fetch address from the core.
- Ctrl  out  8  decoded field.
- Sel  out  4  decoded field.
- Wen  out  1  decoded field.
- WA  out  4  decoded field.
- RAA  out  4  decoded field.
- RAB  out  4  decoded field.
- Op  out  3  decoded field.
- JP  out  1  decoded field.
- JF  out  1  decoded field.
- JumpAddress  out  PCSIZE  decoded field.
- prog_len_o  out  PCSIZE+1  number of loaded words.
- done_o  out  1  one-cycle pulse when the program runs off its end.
- err_o  out  1  sticky load-overflow flag.

Behaviour:
- Instruction layout, MSB to LSB: Ctrl[8] Sel[4] Wen[1] WA[4] RAA[4] RAB[4] Op[3] JP[1] JF[1] JumpAddress[PCSIZE].
- Fetch is combinational: fields = mem[PCAddress] when state==RUN and PCAddress < prog_len; otherwise every field is 0 (NOP).
- State machine has four states: EMPTY, LOAD, LOADED, RUN. Reset state is EMPTY.
- Reset values: prog_len=0, wptr=0, start_o=0, done_o=0, err_o=0, prog_ready_o=0. Memory contents are not reset.
- EMPTY:
  - prog_start_i -> LOAD; wptr<=0; err_o<=0.
  - start_i is ignored.
- LOAD:
  - prog_ready_o=1 (combinational from state).
  - A word is accepted on prog_valid_i&prog_ready_o: mem[wptr]<=prog_data_i; wptr<=wptr+1.
  - If prog_last_i is set on an accepted word: prog_len<=wptr+1; go to LOADED.
  - If the accepted word is at wptr==DEPTH-1 and prog_last_i=0: err_o<=1; prog_len<=0; go to EMPTY.
  - If the word at DEPTH-1 has prog_last_i=1: valid load, prog_len=DEPTH.
  - start_i and prog_start_i are ignored.
- LOADED:
  - start_i -> RUN; start_o=1 for exactly one cycle, registered (cycle after start_i sampled).
  - prog_start_i -> LOAD (reload); prog_len<=0.
  - If start_i and prog_start_i are both high, prog_start_i wins.
- RUN:
  - If PCAddress >= prog_len at a clock edge: done_o<=1 for one cycle; go to LOADED.
  - prog_start_i and start_i are ignored.
- Further rules:
  - start_o and done_o never assert in the same cycle.
  - start_o is never asserted outside the LOADED->RUN transition.
  - Reset mid-LOAD or mid-RUN returns to EMPTY immediately (asynchronous): outputs go NOP, prog_len=0, and the program must be reloaded.
  - prog_valid_i outside LOAD is dropped without side effects.

Test Plan:
- Reset, then prog_start_i plus 3 words (0x...01, 0x...02, last=1 on 0x...03) -> prog_len_o=3, state LOADED; PCAddress=1 gives all fields 0 before start.
- From LOADED, start_i pulse -> start_o high exactly 1 cycle later for 1 cycle. With PCAddress=2, fields decode word 3; a word 0x3F_A_1_5_6_7_3_1_0_2A splits to Ctrl=0x3F, Sel=0xA, Wen=1, WA=5, RAA=6, RAB=7, Op=3, JP=1, JF=0, JumpAddress=0x2A.
- In RUN with prog_len=3, drive PCAddress=3 -> fields 0 in that cycle; done_o=1 next cycle; state back to LOADED; a second start_i works again.
- Load 256 words with PCSIZE=8, last never set -> err_o=1 after the 256th accept, prog_len_o=0, prog_ready_o=0. Load 256 words with last on the 256th -> prog_len_o=256, err_o=0.
- Stall and ignore cases:
  - prog_valid_i toggling with gaps during LOAD -> only valid cycles write; wptr is exact.
  - start_i during LOAD -> no start_o.
  - prog_start_i during RUN -> ignored.
- Assert rst asynchronously mid-RUN -> outputs NOP and prog_len_o=0 without waiting for a clock edge; start_i afterwards gives no start_o until a reload.

Source files
------------

// File: rtl/onectr_progmem.sv
// onectr_progmem
// Loadable program memory and instruction decoder that feeds the ones-counter core.
// A program is streamed in over a valid/ready port. The block then gates the core's
// start request. It presents decoded instruction fields only while a resident program
// is running and the fetch address lies inside it. Otherwise every field is held at
// zero, which the core executes as a NOP.

module onectr_progmem #(
  parameter int PCSIZE = 8,
  parameter int IWIDTH = 30 + PCSIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_start_i,
  input  logic              prog_valid_i,
  output logic              prog_ready_o,
  input  logic [IWIDTH-1:0] prog_data_i,
  input  logic              prog_last_i,
  input  logic              start_i,
  output logic              start_o,
  input  logic [PCSIZE-1:0] PCAddress,
  output logic [7:0]        Ctrl,
  output logic [3:0]        Sel,
  output logic              Wen,
  output logic [3:0]        WA,
  output logic [3:0]        RAA,
  output logic [3:0]        RAB,
  output logic [2:0]        Op,
  output logic              JP,
  output logic              JF,
  output logic [PCSIZE-1:0] JumpAddress,
  output logic [PCSIZE:0]   prog_len_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int DEPTH = 2 ** PCSIZE;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    LOADED,
    RUN
  } state_t;

  state_t state;
  state_t next_state;

  // The write pointer is PCSIZE bits wide. The final slot DEPTH-1 is detected from
  // the pointer itself, so the pointer never needs to hold DEPTH.
  logic [PCSIZE-1:0] wptr;
  logic [PCSIZE-1:0] next_wptr;

  // The program length needs one extra bit so that a full memory reads as DEPTH.
  logic [PCSIZE:0]   prog_len;
  logic [PCSIZE:0]   next_len;

  logic              next_err;
  logic              start_next;
  logic              done_next;
  logic              wr_en;
  logic              wptr_at_end;
  logic              in_range;
  logic [IWIDTH-1:0] fetch_word;

  logic [IWIDTH-1:0] mem [DEPTH];

  assign wptr_at_end = &wptr;

  // A fetch is live only while running and while the core's PC is inside the program.
  assign in_range   = (state == RUN) && ({1'b0, PCAddress} < prog_len);
  assign fetch_word = in_range ? mem[PCAddress] : '0;

  assign {Ctrl, Sel, Wen, WA, RAA, RAB, Op, JP, JF, JumpAddress} = fetch_word;

  assign prog_len_o = prog_len;

  // Next-state logic, load bookkeeping and the one-cycle start/done requests.
  always_comb begin
    next_state   = state;
    next_wptr    = wptr;
    next_len     = prog_len;
    next_err     = err_o;
    start_next   = 1'b0;
    done_next    = 1'b0;
    wr_en        = 1'b0;
    prog_ready_o = 1'b0;
    unique case (state)
      EMPTY: begin
        if (prog_start_i) begin
          next_state = LOAD;
          next_wptr  = '0;
          next_err   = 1'b0;
        end
      end
      LOAD: begin
        prog_ready_o = 1'b1;
        if (prog_valid_i) begin
          wr_en     = 1'b1;
          next_wptr = wptr + 1'b1;
          if (prog_last_i) begin
            next_len   = {1'b0, wptr} + 1'b1;
            next_state = LOADED;
          end else if (wptr_at_end) begin
            next_err   = 1'b1;
            next_len   = '0;
            next_state = EMPTY;
          end
        end
      end
      LOADED: begin
        if (prog_start_i) begin
          next_state = LOAD;
          next_len   = '0;
          next_wptr  = '0;
        end else if (start_i) begin
          next_state = RUN;
          start_next = 1'b1;
        end
      end
      RUN: begin
        if (!in_range) begin
          next_state = LOADED;
          done_next  = 1'b1;
        end
      end
      default: begin
        next_state = EMPTY;
      end
    endcase
  end

  // State register. Reset drops straight back to EMPTY so the outputs become NOPs at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Pointer, length, sticky error and the registered start/done pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      prog_len <= '0;
      err_o    <= 1'b0;
      start_o  <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      wptr     <= next_wptr;
      prog_len <= next_len;
      err_o    <= next_err;
      start_o  <= start_next;
      done_o   <= done_next;
    end
  end

  // Program storage. It has no reset, because a valid length is what makes its contents visible.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= prog_data_i;
    end
  end

endmodule

// File: tb/tb_onectr_progmem.sv
// tb_onectr_progmem
// Self-checking bench for the program memory and decoder. It has three parts: a
// vector table of {PC, expected fields} records, a scoreboard queue of expected
// decodes, and hand-written sequences for the multi-cycle load/run/reset corners.

module tb_onectr_progmem;

  localparam int PCSIZE = 8;
  localparam int IWIDTH = 30 + PCSIZE;
  localparam int DEPTH  = 2 ** PCSIZE;

  logic              clk = 1'b0;
  logic              rst;
  logic              prog_start_i;
  logic              prog_valid_i;
  logic              prog_ready_o;
  logic [IWIDTH-1:0] prog_data_i;
  logic              prog_last_i;
  logic              start_i;
  logic              start_o;
  logic [PCSIZE-1:0] PCAddress;
  logic [7:0]        Ctrl;
  logic [3:0]        Sel;
  logic              Wen;
  logic [3:0]        WA;
  logic [3:0]        RAA;
  logic [3:0]        RAB;
  logic [2:0]        Op;
  logic              JP;
  logic              JF;
  logic [PCSIZE-1:0] JumpAddress;
  logic [PCSIZE:0]   prog_len_o;
  logic              done_o;
  logic              err_o;

  typedef struct packed {
    logic [7:0]        ctrl;
    logic [3:0]        sel;
    logic              wen;
    logic [3:0]        wa;
    logic [3:0]        raa;
    logic [3:0]        rab;
    logic [2:0]        op;
    logic              jp;
    logic              jf;
    logic [PCSIZE-1:0] ja;
  } fields_t;

  typedef struct {
    logic [PCSIZE-1:0] pc;
    bit                active;
    fields_t           f;
  } vec_t;

  int checks = 0;
  int errors = 0;

  fields_t           sb_q[$];
  fields_t           dut_f;
  fields_t           ex_f;
  fields_t           jf1;
  fields_t           jf2;
  logic [IWIDTH-1:0] img [DEPTH];
  vec_t              vecs [7];

  assign dut_f = {Ctrl, Sel, Wen, WA, RAA, RAB, Op, JP, JF, JumpAddress};

  onectr_progmem #(.PCSIZE(PCSIZE)) dut (
    .clk          (clk),
    .rst          (rst),
    .prog_start_i (prog_start_i),
    .prog_valid_i (prog_valid_i),
    .prog_ready_o (prog_ready_o),
    .prog_data_i  (prog_data_i),
    .prog_last_i  (prog_last_i),
    .start_i      (start_i),
    .start_o      (start_o),
    .PCAddress    (PCAddress),
    .Ctrl         (Ctrl),
    .Sel          (Sel),
    .Wen          (Wen),
    .WA           (WA),
    .RAA          (RAA),
    .RAB          (RAB),
    .Op           (Op),
    .JP           (JP),
    .JF           (JF),
    .JumpAddress  (JumpAddress),
    .prog_len_o   (prog_len_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Watchdog so that a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  task automatic applyStimulus(input logic [PCSIZE-1:0] pc, input fields_t want);
    PCAddress = pc;
    sb_q.push_back(want);
  endtask

  task automatic checkOutput(input string name);
    fields_t want;
    #2;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: got empty scoreboard expected a queued decode", name);
    end else begin
      want = sb_q.pop_front();
      if (dut_f !== want) begin
        errors++;
        $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, dut_f, want);
      end
    end
  endtask

  task automatic setVec(input int idx, input logic [PCSIZE-1:0] pc, input bit active,
                        input logic [7:0] c, input logic [3:0] s, input logic w,
                        input logic [3:0] wa, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [2:0] op, input logic jp, input logic jf,
                        input logic [PCSIZE-1:0] ja);
    fields_t f;
    f.ctrl = c;  f.sel = s;  f.wen = w;  f.wa = wa; f.raa = ra;
    f.rab = rb;  f.op = op;  f.jp = jp;  f.jf = jf; f.ja = ja;
    vecs[idx].pc     = pc;
    vecs[idx].active = active;
    vecs[idx].f      = f;
  endtask

  // Requests a load and streams img[0..n-1]. Gap cycles carry junk data with last set,
  // and they must not be accepted.
  task automatic loadProgram(input int n, input bit lastOnFinal, input bit withGaps,
                             input bit startDuring);
    prog_start_i = 1'b1;
    tick();
    prog_start_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (withGaps && (i % 2 == 1)) begin
        prog_valid_i = 1'b0;
        prog_data_i  = ~img[i];
        prog_last_i  = 1'b1;
        start_i      = startDuring;
        tick();
        start_i = 1'b0;
        checkVal("ready_in_load", 32'(prog_ready_o), 32'd1);
        if (startDuring) checkVal("start_ignored_in_load", 32'(start_o), 32'd0);
      end
      prog_valid_i = 1'b1;
      prog_data_i  = img[i];
      prog_last_i  = lastOnFinal && (i == n - 1);
      tick();
    end
    prog_valid_i = 1'b0;
    prog_last_i  = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    prog_start_i = 1'b0;
    prog_valid_i = 1'b0;
    prog_data_i  = '0;
    prog_last_i  = 1'b0;
    start_i      = 1'b0;
    PCAddress    = '0;

    ex_f = {8'h3F, 4'hA, 1'b1, 4'h5, 4'h6, 4'h7, 3'h3, 1'b1, 1'b0, 8'h2A};
    jf1  = {8'h00, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 3'h0, 1'b0, 1'b0, 8'h01};
    jf2  = {8'h00, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 3'h0, 1'b0, 1'b0, 8'h02};

    setVec(0, 8'd3, 1'b1, 8'hFF, 4'hF, 1'b1, 4'hF, 4'hF, 4'hF, 3'h7, 1'b1, 1'b1, 8'hFF);
    setVec(1, 8'd0, 1'b1, 8'hAA, 4'h5, 1'b0, 4'hA, 4'h5, 4'hA, 3'h2, 1'b1, 1'b0, 8'h55);
    setVec(2, 8'd5, 1'b1, 8'h55, 4'hA, 1'b1, 4'h5, 4'hA, 4'h5, 3'h5, 1'b0, 1'b1, 8'hAA);
    setVec(3, 8'd1, 1'b1, 8'h80, 4'h1, 1'b0, 4'h8, 4'h4, 4'h2, 3'h1, 1'b0, 1'b1, 8'h01);
    setVec(4, 8'd4, 1'b1, 8'h01, 4'h8, 1'b1, 4'h1, 4'h2, 4'h4, 3'h4, 1'b1, 1'b0, 8'h80);
    setVec(5, 8'd2, 1'b1, 8'h00, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 3'h0, 1'b0, 1'b0, 8'h00);
    setVec(6, 8'd6, 1'b0, 8'h00, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 3'h0, 1'b0, 1'b0, 8'h00);

    // Reset state.
    #1;
    checkVal("reset_prog_len", 32'(prog_len_o), 32'd0);
    checkVal("reset_ready", 32'(prog_ready_o), 32'd0);
    checkVal("reset_start", 32'(start_o), 32'd0);
    checkVal("reset_done", 32'(done_o), 32'd0);
    checkVal("reset_err", 32'(err_o), 32'd0);
    applyStimulus(8'd0, '0);
    checkOutput("reset_fields");
    #11;
    rst = 1'b0;
    tick();

    // The block must ignore start and stray words while EMPTY.
    start_i      = 1'b1;
    prog_valid_i = 1'b1;
    prog_last_i  = 1'b1;
    prog_data_i  = {IWIDTH{1'b1}};
    tick();
    start_i      = 1'b0;
    prog_valid_i = 1'b0;
    prog_last_i  = 1'b0;
    checkVal("empty_no_start", 32'(start_o), 32'd0);
    checkVal("empty_drop_word", 32'(prog_len_o), 32'd0);
    checkVal("empty_not_ready", 32'(prog_ready_o), 32'd0);

    // Three-word program, loaded with gaps and with a start request during the load.
    img[0] = IWIDTH'(1);
    img[1] = IWIDTH'(2);
    img[2] = ex_f;
    loadProgram(3, 1'b1, 1'b1, 1'b1);
    checkVal("p1_len", 32'(prog_len_o), 32'd3);
    checkVal("p1_not_ready", 32'(prog_ready_o), 32'd0);
    checkVal("p1_err", 32'(err_o), 32'd0);
    applyStimulus(8'd1, '0);
    checkOutput("p1_nop_before_start");
    tick();

    // Start: start_o is registered and lasts exactly one cycle.
    PCAddress = 8'd0;
    start_i   = 1'b1;
    tick();
    start_i = 1'b0;
    checkVal("start_pulse", 32'(start_o), 32'd1);
    checkVal("start_no_done", 32'(done_o), 32'd0);
    tick();
    checkVal("start_width", 32'(start_o), 32'd0);
    applyStimulus(8'd0, jf1);
    checkOutput("run_pc0");
    tick();
    applyStimulus(8'd2, ex_f);
    checkOutput("run_pc2_split");
    tick();

    // Requests to reload or restart while running are ignored.
    prog_start_i = 1'b1;
    start_i      = 1'b1;
    applyStimulus(8'd1, jf2);
    tick();
    prog_start_i = 1'b0;
    start_i      = 1'b0;
    checkVal("run_ignore_prog_start", 32'(prog_ready_o), 32'd0);
    checkVal("run_ignore_start", 32'(start_o), 32'd0);
    checkOutput("run_pc1_after_requests");
    tick();

    // Running off the end: the fetch is a NOP at once, and done pulses one cycle later.
    applyStimulus(8'd3, '0);
    checkOutput("pc_at_len_nop");
    tick();
    checkVal("done_pulse", 32'(done_o), 32'd1);
    checkVal("done_no_start", 32'(start_o), 32'd0);
    tick();
    checkVal("done_width", 32'(done_o), 32'd0);
    applyStimulus(8'd2, '0);
    checkOutput("loaded_nop");
    tick();

    // A second start works from LOADED.
    PCAddress = 8'd0;
    start_i   = 1'b1;
    tick();
    start_i = 1'b0;
    checkVal("second_start", 32'(start_o), 32'd1);
    tick();
    applyStimulus(8'd2, ex_f);
    checkOutput("second_run_decode");
    PCAddress = 8'd200;
    tick();
    checkVal("second_done", 32'(done_o), 32'd1);
    tick();

    // Reload from LOADED with the table program and walk it in scrambled order.
    for (int k = 0; k < 7; k++) begin
      if (vecs[k].active) img[vecs[k].pc] = vecs[k].f;
    end
    loadProgram(6, 1'b1, 1'b0, 1'b0);
    checkVal("table_len", 32'(prog_len_o), 32'd6);
    PCAddress = 8'd0;
    start_i   = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    for (int k = 0; k < 7; k++) begin
      applyStimulus(vecs[k].pc, vecs[k].active ? vecs[k].f : fields_t'(0));
      checkOutput($sformatf("table_vec%0d", k));
      tick();
    end
    checkVal("table_done", 32'(done_o), 32'd1);
    tick();

    // Overflow: 256 words with last never set.
    for (int i = 0; i < DEPTH; i++) img[i] = IWIDTH'({$urandom(), $urandom()});
    loadProgram(DEPTH, 1'b0, 1'b0, 1'b0);
    checkVal("ovf_err", 32'(err_o), 32'd1);
    checkVal("ovf_len", 32'(prog_len_o), 32'd0);
    checkVal("ovf_not_ready", 32'(prog_ready_o), 32'd0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checkVal("ovf_no_start", 32'(start_o), 32'd0);
    checkVal("ovf_err_sticky", 32'(err_o), 32'd1);

    // Full memory: 256 words with last on the final word.
    loadProgram(DEPTH, 1'b1, 1'b0, 1'b0);
    checkVal("full_len", 32'(prog_len_o), 32'd256);
    checkVal("full_err_cleared", 32'(err_o), 32'd0);
    checkVal("full_not_ready", 32'(prog_ready_o), 32'd0);
    PCAddress = 8'd0;
    start_i   = 1'b1;
    tick();
    start_i = 1'b0;
    checkVal("full_start", 32'(start_o), 32'd1);
    tick();
    applyStimulus(8'd255, fields_t'(img[255]));
    checkOutput("full_pc255");
    tick();
    applyStimulus(8'd128, fields_t'(img[128]));
    checkOutput("full_pc128");

    // Asynchronous reset in the middle of a RUN cycle.
    #2;
    rst = 1'b1;
    #1;
    checkVal("async_len", 32'(prog_len_o), 32'd0);
    applyStimulus(8'd128, '0);
    checkOutput("async_nop");
    #4;
    rst = 1'b0;
    PCAddress = 8'd0;
    start_i   = 1'b1;
    tick();
    checkVal("post_reset_no_start0", 32'(start_o), 32'd0);
    tick();
    start_i = 1'b0;
    checkVal("post_reset_no_start1", 32'(start_o), 32'd0);
    checkVal("post_reset_len", 32'(prog_len_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
